// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array processing elements.
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int EXT_MAX    = 128;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } pe_ctrl_t;

  // Widen a pw-bit product to EXT_MAX bits, sign- or zero-filling.
  function automatic logic [EXT_MAX-1:0] ext_prod(
    input logic [EXT_MAX-1:0] p,
    input int                 pw,
    input logic               sgn
  );
    logic [EXT_MAX-1:0] r;
    int                 sh;
    sh = EXT_MAX - pw;
    r  = p << sh;
    if (sgn) r = $unsigned($signed(r) >>> sh);
    else     r = r >> sh;
    return r;
  endfunction

endpackage

// File: rtl/systolic_pe_acc_sat.sv
// Combinational add-or-load with overflow detect and optional clamp.
module pe_acc_sat #(
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] prod,
  input  logic             load,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam logic SG  = (SIGNED != 0);
  localparam logic SAT = (SATURATE != 0);

  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   a;
  logic [ACC_W:0]   b;
  logic [ACC_W:0]   sum;

  always_comb begin
    base   = load ? '0 : acc;
    a      = {SG & base[ACC_W-1], base};
    b      = {SG & prod[ACC_W-1], prod};
    sum    = a + b;
    ovf    = SG ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
    result = sum[ACC_W-1:0];
    // One guard bit holds the true sign, so it picks the clamp rail.
    if (SAT && ovf) begin
      if (!SG)
        result = '1;
      else if (sum[ACC_W])
        result = {1'b1, {(ACC_W-1){1'b0}}};
      else
        result = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Output-stationary MAC processing element with a drain shift stage.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_west,
  input  logic              in_west_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_north,
  input  logic              in_north_valid,
  output logic [DATA_W-1:0] out_east,
  output logic              out_east_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [DATA_W-1:0] out_south,
  output logic              out_south_valid,
  input  logic              drain_en,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_in_valid,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_out_valid,
  output logic              ovf,
  output logic              err
);

  localparam logic SG = (SIGNED != 0);
  localparam int   PW = 2 * DATA_W;

  pe_ctrl_t          wctl;
  pe_ctrl_t          wctl_q;
  logic [DATA_W-1:0] east_q;
  logic [DATA_W-1:0] south_q;
  logic              south_v_q;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  hold;
  logic              hold_v;
  logic              sat_ovf;

  logic [PW-1:0]      wx;
  logic [PW-1:0]      nx;
  logic [PW-1:0]      prod;
  logic [EXT_MAX-1:0] prod_w;
  logic [EXT_MAX-1:0] prod_x;
  logic [ACC_W-1:0]   prod_ext;

  logic fire;
  logic mismatch;
  logic capture;

  assign wctl = '{valid: in_west_valid,
                  first: in_first,
                  last:  in_last};

  assign fire     = in_west_valid & in_north_valid;
  assign mismatch = in_west_valid ^ in_north_valid;
  assign capture  = fire & in_last;

  // Low PW bits of the product are identical for signed and unsigned.
  assign wx = {{DATA_W{SG & in_west[DATA_W-1]}}, in_west};
  assign nx = {{DATA_W{SG & in_north[DATA_W-1]}}, in_north};
  assign prod = wx * nx;

  assign prod_w   = {{(EXT_MAX-PW){1'b0}}, prod};
  assign prod_x   = ext_prod(prod_w, PW, SG);
  assign prod_ext = prod_x[ACC_W-1:0];

  pe_acc_sat #(
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_acc (
    .acc    (acc),
    .prod   (prod_ext),
    .load   (in_first),
    .result (acc_next),
    .ovf    (sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wctl_q    <= '0;
      east_q    <= '0;
      south_q   <= '0;
      south_v_q <= 1'b0;
      acc       <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      wctl_q    <= wctl;
      east_q    <= in_west;
      south_q   <= in_north;
      south_v_q <= in_north_valid;

      if (fire) begin
        acc <= capture ? '0 : acc_next;
        if (sat_ovf) ovf <= 1'b1;
      end

      if (mismatch) err <= 1'b1;

      // A capture always beats a drain shift in the same cycle.
      if (capture) begin
        hold   <= acc_next;
        hold_v <= 1'b1;
        if (drain_en || hold_v) err <= 1'b1;
      end else if (drain_en) begin
        hold   <= drain_in;
        hold_v <= drain_in_valid;
      end
    end
  end

  assign out_east        = east_q;
  assign out_east_valid  = wctl_q.valid;
  assign out_first       = wctl_q.first;
  assign out_last        = wctl_q.last;
  assign out_south       = south_q;
  assign out_south_valid = south_v_q;
  assign drain_out       = hold;
  assign drain_out_valid = hold_v;

endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
Parametrised output-stationary processing element, the next-generation PE for the systolic matrix-multiply array. Operands flow west→east and north→south with per-lane valids. Tile framing flags delimit each dot product. Products accumulate with optional saturation. Finished results are captured into a hold register that doubles as a stage of a column-wise drain shift chain.

Parameters:
DATA_W, 8, operand width
ACC_W, 32, accumulator/result width; must be ≥ 2*DATA_W
SIGNED, 1, 1 = two's-complement operands/accumulator, 0 = unsigned
SATURATE, 0, 1 = clamp accumulator at ACC_W range, 0 = wrap modulo 2^ACC_W

Ports:
clk  in  1  clock
rst  in  1  reset, active-low
in_west  in  DATA_W  row operand
in_west_valid  in  1  row operand valid
in_first  in  1  tile start flag, qualified by in_west_valid
in_last  in  1  tile end flag, qualified by in_west_valid
in_north  in  DATA_W  column operand
in_north_valid  in  1  column operand valid
out_east / out_east_valid / out_first / out_last  out  DATA_W/1/1/1  registered copies of west-side inputs
out_south / out_south_valid  out  DATA_W/1  registered copies of north-side inputs
drain_en  in  1  shift drain chain one stage
drain_in / drain_in_valid  in  ACC_W/1  from north neighbour's drain_out
drain_out / drain_out_valid  out  ACC_W/1  hold register contents
ovf  out  1  sticky: saturation or wrap occurred
err  out  1  sticky: valid mismatch or capture/drain collision

Behaviour:
- Reset: one clock, synchronous, active-low (rst=0 at posedge clk). All outputs, accumulator, hold register, ovf and err go to 0.
- Pass-through: every cycle, out_east/out_south and their valid/flag bits register their inputs unconditionally. Latency is 1 cycle regardless of fire.
- fire = in_west_valid & in_north_valid.
- Product: full 2*DATA_W product, sign- or zero-extended to ACC_W per SIGNED.
- On fire:
  - acc_next = product if in_first, else acc + product.
  - Accumulator updates at the next edge.
- No fire: accumulator holds. Flags are ignored when in_west_valid=0.
- Exactly one valid high: no MAC, err←1.
- in_last with fire:
  - Hold register ← acc_next and hold valid ← 1 at the same edge.
  - Accumulator ← 0.
  - in_first & in_last together: hold ← product, so a single-element tile is legal.
- Arithmetic:
  - SATURATE=1: clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1] if SIGNED, else [0, 2^ACC_W−1]; ovf←1 on clamp.
  - SATURATE=0: wrap; ovf←1 on signed/unsigned overflow.
- Drain:
  - drain_out/drain_out_valid continuously reflect the hold register.
  - drain_en=1 and no capture that cycle: hold ← drain_in, hold valid ← drain_in_valid.
  - drain_en=0: hold keeps its value.
- Collision (drain_en and last-fire in the same cycle): capture wins, drain_in is dropped, err←1.
- Second capture while hold valid=1 with no intervening drain: overwrite, err←1.
- ovf and err clear only on reset.
- Reset mid-tile: partial accumulation is discarded, no result is emitted, and the first fire after reset without in_first accumulates from 0.

Decomposition:
- Package systolic_pkg holds:
  - default DATA_W/ACC_W constants
  - a pe_ctrl_t struct {valid, first, last}
  - a function that extends a product to ACC_W
- One sub-module: pe_acc_sat, the combinational add-or-load, overflow detect and clamp, parametrised by ACC_W, SIGNED, SATURATE.

Test Plan:
1. SIGNED=1: stream (3,4),(−2,5),(7,−1) with first on beat 1 and last on beat 3 → hold=−5, drain_out_valid=1 at the edge after beat 3; out_east/out_south echo each operand one cycle later.
2. SATURATE=1, SIGNED=1, ACC_W=16: repeat (127,127) ×3 with first/last framing → drain_out=32767, ovf=1. With SATURATE=0 → drain_out=−17149 (48387 mod 2^16, signed), ovf=1.
3. SIGNED=0: single beat (255,255) with first&last → drain_out=65025, ovf=0; then in_north_valid=1 with in_west_valid=0 → acc unchanged, err=1.
4. Drain chain of 3 PEs, each holding 10, 20, 30; assert drain_en for 3 cycles with drain_in_valid=0 at the top → bottom drain_out shows 30, 20, 10, then drain_out_valid=0.
5. drain_en=1 in the same cycle as a last-fire with result 42 → hold=42, err=1, upstream drain_in value lost.
6. rst=0 for one cycle after 2 of 4 beats of a tile → all outputs 0. Post-reset beats (2,2),(3,3) with last on the second beat and no first → drain_out=13.
